// File: rtl/rate_encoding_pkg.sv
// Shared constants, FSM state type and width helpers for the rate-encoding spike generator.
package rate_encoding_pkg;

  localparam int PROD_WIDTH = 15;

  // Fibonacci taps for x^15 + x^14 + 1 (maximal length, 32767 states)
  localparam int LFSR_TAP_HI = 14;
  localparam int LFSR_TAP_LO = 13;
  localparam logic [PROD_WIDTH-1:0] LFSR_DEFAULT_SEED = 15'h0001;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int step_width(input int num_steps);
    return (num_steps > 1) ? $clog2(num_steps) : 1;
  endfunction

  function automatic int count_width(input int num_steps);
    return $clog2(num_steps + 1);
  endfunction

endpackage

// File: rtl/rate_encoding_spike_gen_if.sv
// Product input stream and spike output stream of the spike generator.
interface rate_encoding_spike_gen_if
  import rate_encoding_pkg::*;
#(
  parameter int NUM_STEPS = 16
);

  localparam int STEP_W  = step_width(NUM_STEPS);
  localparam int COUNT_W = count_width(NUM_STEPS);

  logic                  in_valid;
  logic                  in_ready;
  logic [PROD_WIDTH-1:0] in_product;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_spike;
  logic [STEP_W-1:0]     out_step;
  logic                  out_last_step;
  logic                  out_frame_last;
  logic [COUNT_W-1:0]    out_count;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_spike, out_step, out_last_step, out_frame_last, out_count
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_spike, out_step, out_last_step, out_frame_last, out_count
  );

endinterface

// File: rtl/rate_encoding_lfsr15.sv
// 15-bit Fibonacci LFSR that advances only when enabled; reloads SEED on reset.
module rate_encoding_lfsr15
  import rate_encoding_pkg::*;
#(
  parameter logic [14:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        en,
  output logic [14:0] q
);

  logic [14:0] r_q;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_q <= SEED;
    end else if (en) begin
      r_q <= {r_q[13:0], r_q[LFSR_TAP_HI] ^ r_q[LFSR_TAP_LO]};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/rate_encoding_spike_gen.sv
// Bernoulli spike-train generator: per pixel, NUM_STEPS beats of (lfsr < threshold)
// with a running spike count, streamed out over valid/ready.
module rate_encoding_spike_gen
  import rate_encoding_pkg::*;
#(
  parameter int                    NUM_STEPS = 16,
  parameter logic [PROD_WIDTH-1:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  rate_encoding_spike_gen_if.slave s
);

  localparam int STEP_W  = step_width(NUM_STEPS);
  localparam int COUNT_W = count_width(NUM_STEPS);

  state_t                r_state;
  state_t                w_next_state;
  logic [PROD_WIDTH-1:0] r_thr;
  logic                  r_last;
  logic [STEP_W-1:0]     r_step;
  logic [COUNT_W-1:0]    r_count;
  logic [PROD_WIDTH-1:0] w_lfsr;
  logic                  w_accept;
  logic                  w_beat;
  logic                  w_spike;
  logic                  w_final;

  assign w_accept = s.in_valid && (r_state == IDLE);
  assign w_beat   = (r_state == RUN) && s.out_ready;
  assign w_spike  = (r_state == RUN) && (w_lfsr < r_thr);
  assign w_final  = (r_step == STEP_W'(NUM_STEPS - 1));

  rate_encoding_lfsr15 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .en     (w_beat),
    .q      (w_lfsr)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = RUN;
      RUN:     if (w_beat && w_final) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Step and count clear on the final beat so the idle outputs read zero.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_thr   <= '0;
      r_last  <= 1'b0;
      r_step  <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_thr   <= s.in_product;
      r_last  <= s.in_last;
      r_step  <= '0;
      r_count <= '0;
    end else if (w_beat) begin
      if (w_final) begin
        r_step  <= '0;
        r_count <= '0;
      end else begin
        r_step  <= r_step + STEP_W'(1);
        r_count <= r_count + COUNT_W'(w_spike);
      end
    end
  end

  always_comb begin
    s.in_ready       = (r_state == IDLE);
    s.out_valid      = (r_state == RUN);
    s.out_spike      = w_spike;
    s.out_step       = r_step;
    s.out_last_step  = (r_state == RUN) && w_final;
    s.out_frame_last = (r_state == RUN) && w_final && r_last;
    s.out_count      = r_count + COUNT_W'(w_spike);
  end

endmodule

// File: tb/tb_rate_encoding_spike_gen.sv
// Directed bench for rate_encoding_spike_gen: hand-computed spike masks and counts,
// per-beat reference LFSR, backpressure, back-to-back pixels and mid-train reset.
module tb_rate_encoding_spike_gen;
  import rate_encoding_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rate_encoding_spike_gen_if #(.NUM_STEPS(16)) bus ();

  rate_encoding_spike_gen #(
    .NUM_STEPS (16),
    .LFSR_SEED (15'h0001)
  ) dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .s      (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [14:0] m_lfsr = 15'h0001;
  logic [15:0] dut_mask;
  int          dut_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [14:0] lfsr_next(input logic [14:0] v);
    return {v[13:0], v[14] ^ v[13]};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_out_valid"},  32'(bus.out_valid), 32'd0);
    check_eq({tag, "_in_ready"},   32'(bus.in_ready), 32'd1);
    check_eq({tag, "_out_spike"},  32'(bus.out_spike), 32'd0);
    check_eq({tag, "_last_step"},  32'(bus.out_last_step), 32'd0);
    check_eq({tag, "_frame_last"}, 32'(bus.out_frame_last), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check_idle_outputs("reset");
    check_eq("reset_out_count", 32'(bus.out_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_lfsr = 15'h0001;
  endtask

  // Offers one product, then checks every beat (including stall cycles) against the model.
  task automatic run_pixel(input logic [14:0] thr, input logic last, input bit rnd_ready,
                           input bit keep_valid, input int abort_at);
    int   guard;
    int   step;
    int   cnt;
    logic rdy;
    logic exp_spike;
    bus.in_valid   = 1'b1;
    bus.in_product = thr;
    bus.in_last    = last;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq("accept_wait_in_ready", 32'(bus.in_ready), 32'd1);
    if (bus.in_ready !== 1'b1) return;
    @(posedge clk);
    #1;
    if (!keep_valid) bus.in_valid = 1'b0;
    step = 0;
    cnt = 0;
    dut_mask = '0;
    dut_cnt = -1;
    guard = 0;
    while (step < 16 && guard < 200) begin
      if (step == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        m_lfsr = 15'h0001;
        return;
      end
      rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rdy;
      exp_spike = (m_lfsr < thr);
      check_eq("beat_out_valid",  32'(bus.out_valid), 32'd1);
      check_eq("beat_in_ready",   32'(bus.in_ready), 32'd0);
      check_eq("beat_spike",      32'(bus.out_spike), 32'(exp_spike));
      check_eq("beat_step",       32'(bus.out_step), 32'(step));
      check_eq("beat_count",      32'(bus.out_count), 32'(cnt + int'(exp_spike)));
      check_eq("beat_last_step",  32'(bus.out_last_step), 32'(step == 15));
      check_eq("beat_frame_last", 32'(bus.out_frame_last), 32'((step == 15) && last));
      if (rdy) begin
        dut_mask[step] = bus.out_spike;
        if (step == 15) dut_cnt = int'(bus.out_count);
        cnt += int'(exp_spike);
        m_lfsr = lfsr_next(m_lfsr);
        step++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq("beats_done", 32'(step), 32'd16);
    check_eq("bubble_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("bubble_in_ready",  32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_product = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b1;
    @(posedge clk);
    apply_reset();

    // threshold 0x10 from seed 1: lfsr 1,2,4,8 then 0x0003 at step 15 fall below it
    run_pixel(15'h0010, 1'b0, 1'b0, 1'b0, -1);
    check_eq("p1_mask",  32'(dut_mask), 32'h800F);
    check_eq("p1_count", 32'(dut_cnt), 32'd5);

    run_pixel(15'h0000, 1'b1, 1'b0, 1'b0, -1);
    check_eq("p2_mask",  32'(dut_mask), 32'h0000);
    check_eq("p2_count", 32'(dut_cnt), 32'd0);

    apply_reset();
    run_pixel(15'h7FFF, 1'b0, 1'b0, 1'b0, -1);
    check_eq("full_mask",  32'(dut_mask), 32'hFFFF);
    check_eq("full_count", 32'(dut_cnt), 32'd16);

    apply_reset();
    run_pixel(15'h0010, 1'b0, 1'b1, 1'b0, -1);
    check_eq("bp_mask",  32'(dut_mask), 32'h800F);
    check_eq("bp_count", 32'(dut_cnt), 32'd5);

    // back-to-back with in_valid held high across pixels
    apply_reset();
    run_pixel(15'h7FFF, 1'b0, 1'b0, 1'b1, -1);
    check_eq("b2b_0_count", 32'(dut_cnt), 32'd16);
    run_pixel(15'h0000, 1'b0, 1'b0, 1'b1, -1);
    check_eq("b2b_1_count", 32'(dut_cnt), 32'd0);
    run_pixel(15'h7FFF, 1'b1, 1'b0, 1'b1, -1);
    check_eq("b2b_2_count", 32'(dut_cnt), 32'd16);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("b2b_drained_in_ready", 32'(bus.in_ready), 32'd1);

    apply_reset();
    run_pixel(15'h0010, 1'b0, 1'b0, 1'b0, 7);
    run_pixel(15'h0010, 1'b0, 1'b0, 1'b0, -1);
    check_eq("postrst_mask",  32'(dut_mask), 32'h800F);
    check_eq("postrst_count", 32'(dut_cnt), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rate_encoding_spike_gen.md
Name: rate_encoding_spike_gen

Overview:
Downstream consumer of the rate-encoding multiplier. It takes the 15-bit unsigned product (pixel intensity × gain) as a per-pixel firing threshold. Over NUM_STEPS timesteps it emits a Bernoulli spike train by comparing the threshold against a free-running 15-bit LFSR. It also reports the per-pixel spike count on the final step. Output goes to the SNN input-layer spike FIFO through a valid/ready stream.

Parameters:
PROD_WIDTH, 15, width of incoming product/threshold; must equal the LFSR width.
NUM_STEPS, 16, timesteps generated per pixel; range 2..256.
LFSR_SEED, 15'h0001, LFSR value after reset; must be nonzero.

Ports:
ap_clk  in  1  clock; all state changes on the rising edge.
ap_rst  in  1  asynchronous, active-high reset.
in_valid  in  1  upstream product valid.
in_ready  out  1  block can accept a product.
in_product  in  PROD_WIDTH  unsigned threshold from the multiplier.
in_last  in  1  product belongs to the last pixel of the frame.
out_valid  out  1  spike beat valid.
out_ready  in  1  downstream accepts the beat.
out_spike  out  1  spike for the current timestep.
out_step  out  clog2(NUM_STEPS)  timestep index, 0..NUM_STEPS-1.
out_last_step  out  1  beat is step NUM_STEPS-1.
out_frame_last  out  1  out_last_step AND the latched in_last.
out_count  out  clog2(NUM_STEPS+1)  running spike count for this pixel, including the current beat.

Behaviour:
- Reset (asynchronous, any time, including mid-train):
  - state=IDLE; lfsr=LFSR_SEED; step=0; count=0; thr=0; last=0.
  - out_valid=0, out_spike=0, out_last_step=0, out_frame_last=0.
  - Any pixel in progress is discarded.
- FSM has two states, IDLE and RUN.
- in_ready = (state==IDLE), combinational from state only. There is no combinational in→out path.
- IDLE:
  - On in_valid&in_ready: latch thr=in_product, last=in_last, step=0, count=0; go to RUN.
  - The first beat has out_valid=1 in the next cycle (latency 1 cycle from acceptance).
- RUN:
  - out_valid=1.
  - spike = (lfsr < thr), unsigned compare.
  - out_count = count + spike. All outputs are derived from registered state.
- Beat handshake (out_valid&out_ready):
  - lfsr advances one step; count += spike; step += 1.
  - If step==NUM_STEPS-1: go to IDLE, with in_ready high in the following cycle. There is a mandatory 1-cycle bubble between pixels.
- Backpressure: while out_valid & !out_ready, every output and all internal state (including lfsr) hold stable.
- LFSR:
  - Fibonacci form, x^15+x^14+1: next = {lfsr[13:0], lfsr[14]^lfsr[13]}. Maximal length 32767; never 0.
  - Advances only on an accepted beat.
  - Not reloaded between pixels or frames; reloaded only by reset.
- Boundaries:
  - thr=0 → never spikes.
  - thr=0x7FFF → spikes unless lfsr==0x7FFF.
  - count saturation is impossible by construction (max NUM_STEPS).
  - step wraps to 0 at pixel end.
  - in_valid asserted during RUN is ignored; upstream holds it.
- Widths: compare is unsigned PROD_WIDTH bits; count and step are widths as in Ports, with no truncation.

Decomposition:
- Shared package rate_encoding_pkg holds:
  - PROD_WIDTH
  - LFSR tap positions and default seed
  - FSM state enum {IDLE, RUN}
  - width helper functions for step and count
- One sub-module, rate_encoding_lfsr15: ports ap_clk, ap_rst, en, q[14:0]; parameter SEED.
- Compare, counters and FSM stay in the top module.

Test Plan:
- Reset then product 0x0010, in_last=0, out_ready=1, seed 1:
  - LFSR sequence 1,2,4,…,0x2000,0x4001,0x0003.
  - Spikes at steps 0,1,2,3,15 only; final out_count=5; out_last_step on step 15; out_frame_last=0.
  - in_ready returns 1 one cycle after the last beat.
- Second pixel, product 0x0000, in_last=1:
  - LFSR continues from 0x0006.
  - 16 beats, all out_spike=0; out_count=0; out_frame_last=1 on step 15 only.
- Product 0x7FFF over 16 steps from seed 1: all 16 beats spike; out_count=16.
- Backpressure: toggle out_ready at random over a full pixel → beat sequence identical to the out_ready=1 run, and outputs held stable during every stall cycle.
- Hold in_valid high with back-to-back products → acceptance only in IDLE, one bubble cycle between pixels, no product lost or duplicated.
- Assert ap_rst asynchronously mid-train (step 7) → out_valid=0 immediately (before the next clock edge) and lfsr=seed. After release the next pixel reproduces the scenario-1 sequence.
